accel_dma_shim: RTL and testbench



---
 rtl/accel_dma_shim_if.sv | 69 ++++++
 rtl/accel_dma_shim.sv | 134 +++++++++++++
 tb/tb_accel_dma_shim.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_dma_shim_if.sv
// AXI4 bus bundle shared by the accelerator DMA side and the crossbar side of accel_dma_shim.
// Master drives requests and write data; Slave drives ready, write response and read data.
interface AXI_BUS #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ID_W-1:0]   aw_id;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              aw_valid;
    logic              aw_ready;

    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              w_last;
    logic              w_valid;
    logic              w_ready;

    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready;

    logic [ID_W-1:0]   ar_id;
    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_valid;
    logic              ar_ready;

    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic              r_valid;
    logic              r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/accel_dma_shim.sv
// Shim between an accelerator AXI DMA master and a crossbar slave port: fixed ID/size,
// per-direction outstanding-burst limiting, quiesce/drain handshake and sticky bus-error capture.
module accel_dma_shim #(
    parameter int unsigned     ID_W       = 4,
    parameter logic [ID_W-1:0] AXI_ID     = '0,
    parameter logic [2:0]      AXSIZE     = 3'b010,
    parameter int unsigned     MAX_RD     = 4,
    parameter int unsigned     MAX_WR     = 4,
    parameter bit              ERR_IRQ_EN = 1'b1
) (
    input  logic       aclk,
    input  logic       aresetn,
    AXI_BUS.Slave      acc_slv,
    AXI_BUS.Master     sys_mst,
    input  logic       acc_irq_i,
    input  logic       quiesce_i,
    input  logic       err_clr_i,
    output logic       idle_o,
    output logic       err_o,
    output logic [3:0] rd_cnt_o,
    output logic [3:0] wr_cnt_o,
    output logic       irq_o
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(MAX_RD);
    localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(MAX_WR);

    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             err_q, err_d;

    logic blk_rd, blk_wr;
    logic rd_inc, rd_dec, rd_resp_err, rd_unf;
    logic wr_inc, wr_dec, wr_resp_err, wr_unf;
    logic unused_id_size;

    assign blk_rd = quiesce_i | (rd_cnt_q == RD_LIM);
    assign blk_wr = quiesce_i | (wr_cnt_q == WR_LIM);

    // Write address: ID and size replaced, valid/ready gated by the write block
    assign sys_mst.aw_id    = AXI_ID;
    assign sys_mst.aw_addr  = acc_slv.aw_addr;
    assign sys_mst.aw_len   = acc_slv.aw_len;
    assign sys_mst.aw_size  = AXSIZE;
    assign sys_mst.aw_burst = acc_slv.aw_burst;
    assign sys_mst.aw_valid = acc_slv.aw_valid & ~blk_wr;
    assign acc_slv.aw_ready = sys_mst.aw_ready & ~blk_wr;

    assign sys_mst.w_data   = acc_slv.w_data;
    assign sys_mst.w_strb   = acc_slv.w_strb;
    assign sys_mst.w_last   = acc_slv.w_last;
    assign sys_mst.w_valid  = acc_slv.w_valid;
    assign acc_slv.w_ready  = sys_mst.w_ready;

    assign acc_slv.b_id     = sys_mst.b_id;
    assign acc_slv.b_resp   = sys_mst.b_resp;
    assign acc_slv.b_valid  = sys_mst.b_valid;
    assign sys_mst.b_ready  = acc_slv.b_ready;

    // Read address: same treatment as write address, gated by the read block
    assign sys_mst.ar_id    = AXI_ID;
    assign sys_mst.ar_addr  = acc_slv.ar_addr;
    assign sys_mst.ar_len   = acc_slv.ar_len;
    assign sys_mst.ar_size  = AXSIZE;
    assign sys_mst.ar_burst = acc_slv.ar_burst;
    assign sys_mst.ar_valid = acc_slv.ar_valid & ~blk_rd;
    assign acc_slv.ar_ready = sys_mst.ar_ready & ~blk_rd;

    assign acc_slv.r_id     = sys_mst.r_id;
    assign acc_slv.r_data   = sys_mst.r_data;
    assign acc_slv.r_resp   = sys_mst.r_resp;
    assign acc_slv.r_last   = sys_mst.r_last;
    assign acc_slv.r_valid  = sys_mst.r_valid;
    assign sys_mst.r_ready  = acc_slv.r_ready;

    // The accelerator's own ID/size fields are overridden and deliberately dropped
    assign unused_id_size = ^{acc_slv.aw_id, acc_slv.aw_size, acc_slv.ar_id, acc_slv.ar_size};

    assign rd_inc      = sys_mst.ar_valid & sys_mst.ar_ready;
    assign rd_dec      = sys_mst.r_valid & sys_mst.r_ready & sys_mst.r_last;
    assign rd_resp_err = sys_mst.r_valid & sys_mst.r_ready & sys_mst.r_resp[1];
    assign wr_inc      = sys_mst.aw_valid & sys_mst.aw_ready;
    assign wr_dec      = sys_mst.b_valid & sys_mst.b_ready;
    assign wr_resp_err = wr_dec & sys_mst.b_resp[1];

    // Next-state for counters; a net decrement at zero saturates and flags underflow
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_unf   = 1'b0;
        wr_unf   = 1'b0;
        if (rd_inc && !rd_dec) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (!rd_inc && rd_dec) begin
            if (rd_cnt_q == '0) rd_unf = 1'b1;
            else                rd_cnt_d = rd_cnt_q - CNT_W'(1);
        end
        if (wr_inc && !wr_dec) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (!wr_inc && wr_dec) begin
            if (wr_cnt_q == '0) wr_unf = 1'b1;
            else                wr_cnt_d = wr_cnt_q - CNT_W'(1);
        end
    end

    // Set dominates clear so a same-cycle error is never lost
    always_comb begin
        err_d = err_q & ~err_clr_i;
        if (rd_resp_err || wr_resp_err || rd_unf || wr_unf) err_d = 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
    assign err_o    = err_q;
    assign idle_o   = quiesce_i & (rd_cnt_q == '0) & (wr_cnt_q == '0);
    assign irq_o    = acc_irq_i | (err_q & ERR_IRQ_EN);

    a_rd_no_overrun: assert property (@(posedge aclk) disable iff (!aresetn)
        !(rd_inc && (rd_cnt_q == RD_LIM)));
    a_wr_no_overrun: assert property (@(posedge aclk) disable iff (!aresetn)
        !(wr_inc && (wr_cnt_q == WR_LIM)));
endmodule

// File: tb/tb_accel_dma_shim.sv
// Directed bench for accel_dma_shim: instance A (MAX_RD=2) takes the stimulus, instance B
// (MAX_RD=4) mirrors A's inputs and is used to reach 3 outstanding reads for the reset check.
module tb_accel_dma_shim;
    logic aclk = 1'b0;
    logic aresetn;
    logic acc_irq, quiesce, err_clr;
    logic idle_a, err_a, irq_a, idle_b, err_b, irq_b;
    logic [3:0] rd_a, wr_a, rd_b, wr_b;
    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    AXI_BUS #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) acc_a ();
    AXI_BUS #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) sys_a ();
    AXI_BUS #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) acc_b ();
    AXI_BUS #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) sys_b ();

    accel_dma_shim #(.ID_W(4), .AXI_ID(4'd2), .AXSIZE(3'b011), .MAX_RD(2), .MAX_WR(4),
                     .ERR_IRQ_EN(1'b1)) u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .acc_slv(acc_a), .sys_mst(sys_a),
        .acc_irq_i(acc_irq), .quiesce_i(quiesce), .err_clr_i(err_clr),
        .idle_o(idle_a), .err_o(err_a), .rd_cnt_o(rd_a), .wr_cnt_o(wr_a), .irq_o(irq_a));

    accel_dma_shim #(.ID_W(4), .AXI_ID(4'd2), .AXSIZE(3'b011), .MAX_RD(4), .MAX_WR(4),
                     .ERR_IRQ_EN(1'b1)) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .acc_slv(acc_b), .sys_mst(sys_b),
        .acc_irq_i(acc_irq), .quiesce_i(quiesce), .err_clr_i(err_clr),
        .idle_o(idle_b), .err_o(err_b), .rd_cnt_o(rd_b), .wr_cnt_o(wr_b), .irq_o(irq_b));

    // Instance B sees exactly the same inputs as instance A
    assign acc_b.aw_id    = acc_a.aw_id;
    assign acc_b.aw_addr  = acc_a.aw_addr;
    assign acc_b.aw_len   = acc_a.aw_len;
    assign acc_b.aw_size  = acc_a.aw_size;
    assign acc_b.aw_burst = acc_a.aw_burst;
    assign acc_b.aw_valid = acc_a.aw_valid;
    assign acc_b.w_data   = acc_a.w_data;
    assign acc_b.w_strb   = acc_a.w_strb;
    assign acc_b.w_last   = acc_a.w_last;
    assign acc_b.w_valid  = acc_a.w_valid;
    assign acc_b.b_ready  = acc_a.b_ready;
    assign acc_b.ar_id    = acc_a.ar_id;
    assign acc_b.ar_addr  = acc_a.ar_addr;
    assign acc_b.ar_len   = acc_a.ar_len;
    assign acc_b.ar_size  = acc_a.ar_size;
    assign acc_b.ar_burst = acc_a.ar_burst;
    assign acc_b.ar_valid = acc_a.ar_valid;
    assign acc_b.r_ready  = acc_a.r_ready;
    assign sys_b.aw_ready = sys_a.aw_ready;
    assign sys_b.w_ready  = sys_a.w_ready;
    assign sys_b.b_id     = sys_a.b_id;
    assign sys_b.b_resp   = sys_a.b_resp;
    assign sys_b.b_valid  = sys_a.b_valid;
    assign sys_b.ar_ready = sys_a.ar_ready;
    assign sys_b.r_id     = sys_a.r_id;
    assign sys_b.r_data   = sys_a.r_data;
    assign sys_b.r_resp   = sys_a.r_resp;
    assign sys_b.r_last   = sys_a.r_last;
    assign sys_b.r_valid  = sys_a.r_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0; acc_irq = 1'b0; quiesce = 1'b0; err_clr = 1'b0;
        acc_a.aw_id = '0; acc_a.aw_addr = '0; acc_a.aw_len = '0; acc_a.aw_size = '0;
        acc_a.aw_burst = 2'b01; acc_a.aw_valid = 1'b0;
        acc_a.w_data = '0; acc_a.w_strb = '1; acc_a.w_last = 1'b0; acc_a.w_valid = 1'b0;
        acc_a.b_ready = 1'b0;
        acc_a.ar_id = '0; acc_a.ar_addr = '0; acc_a.ar_len = '0; acc_a.ar_size = '0;
        acc_a.ar_burst = 2'b01; acc_a.ar_valid = 1'b0; acc_a.r_ready = 1'b0;
        sys_a.aw_ready = 1'b0; sys_a.w_ready = 1'b1;
        sys_a.b_id = '0; sys_a.b_resp = '0; sys_a.b_valid = 1'b0;
        sys_a.ar_ready = 1'b0;
        sys_a.r_id = '0; sys_a.r_data = '0; sys_a.r_resp = '0; sys_a.r_last = 1'b0;
        sys_a.r_valid = 1'b0;

        // Reset state
        #2;
        check("rst_rd_cnt", rd_a, 0);
        check("rst_wr_cnt", wr_a, 0);
        check("rst_err", err_a, 0);
        check("rst_idle", idle_a, 0);
        check("rst_irq", irq_a, 0);
        quiesce = 1'b1; #1;
        check("rst_idle_q", idle_a, 1);
        quiesce = 1'b0; acc_irq = 1'b1; #1;
        check("rst_irq_pass", irq_a, 1);
        acc_irq = 1'b0;
        cyc();
        aresetn = 1'b1;

        // ID and size override, r_id returned untouched
        acc_a.ar_id = 4'd5; acc_a.ar_size = 3'b000; acc_a.ar_addr = 32'h1000;
        acc_a.ar_len = 8'd3; acc_a.ar_valid = 1'b1;
        acc_a.aw_id = 4'd6; acc_a.aw_size = 3'b001; sys_a.r_id = 4'd7;
        #1;
        check("ar_id", sys_a.ar_id, 2);
        check("ar_size", sys_a.ar_size, 3);
        check("ar_addr", sys_a.ar_addr, 32'h1000);
        check("ar_valid_pass", sys_a.ar_valid, 1);
        check("ar_ready_pass", acc_a.ar_ready, 0);
        check("aw_id", sys_a.aw_id, 2);
        check("aw_size", sys_a.aw_size, 3);
        check("r_id", acc_a.r_id, 7);
        acc_a.ar_valid = 1'b0;

        // Read limit of 2: third AR stalls until the first r_last
        sys_a.ar_ready = 1'b1; acc_a.ar_valid = 1'b1;
        cyc();
        check("rd_cnt_1", rd_a, 1);
        cyc();
        check("rd_cnt_2", rd_a, 2);
        check("ar_ready_blk", acc_a.ar_ready, 0);
        check("ar_valid_blk", sys_a.ar_valid, 0);
        cyc();
        check("rd_cnt_hold", rd_a, 2);
        sys_a.r_valid = 1'b1; acc_a.r_ready = 1'b1; sys_a.r_last = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        sys_a.r_last = 1'b1; #1;
        check("ar_blk_at_last", acc_a.ar_ready, 0);
        cyc();
        sys_a.r_valid = 1'b0; sys_a.r_last = 1'b0; #1;
        check("rd_cnt_after_last", rd_a, 1);
        check("ar_ready_unblk", acc_a.ar_ready, 1);
        cyc();
        acc_a.ar_valid = 1'b0;
        check("rd_cnt_third", rd_a, 2);
        check("rd_no_err", err_a, 0);
        sys_a.r_valid = 1'b1; sys_a.r_last = 1'b1;
        cyc(); cyc();
        sys_a.r_valid = 1'b0; sys_a.r_last = 1'b0;
        check("rd_cnt_drained", rd_a, 0);

        // Same-cycle AW and B handshake hold the counter
        sys_a.aw_ready = 1'b1; acc_a.aw_valid = 1'b1;
        cyc();
        check("wr_cnt_1", wr_a, 1);
        sys_a.b_valid = 1'b1; acc_a.b_ready = 1'b1; sys_a.b_resp = 2'b00; sys_a.b_id = 4'd9;
        #1;
        check("b_id", acc_a.b_id, 9);
        check("b_valid_pass", acc_a.b_valid, 1);
        cyc();
        check("wr_cnt_simul", wr_a, 1);
        acc_a.aw_valid = 1'b0; sys_a.b_resp = 2'b10; err_clr = 1'b1;
        cyc();
        sys_a.b_valid = 1'b0; sys_a.b_resp = 2'b00; err_clr = 1'b0;
        check("err_set_wins", err_a, 1);
        check("irq_err", irq_a, 1);
        check("wr_cnt_slverr", wr_a, 0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("err_cleared", err_a, 0);
        check("irq_cleared", irq_a, 0);

        // Drain: two writes outstanding, quiesce stalls the third AW
        acc_a.aw_valid = 1'b1;
        cyc(); cyc();
        quiesce = 1'b1; #1;
        check("drain_wr_cnt", wr_a, 2);
        check("drain_aw_ready", acc_a.aw_ready, 0);
        check("drain_aw_valid", sys_a.aw_valid, 0);
        check("drain_idle_0", idle_a, 0);
        cyc();
        check("drain_wr_hold", wr_a, 2);
        sys_a.b_valid = 1'b1;
        cyc();
        sys_a.b_valid = 1'b0;
        check("drain_wr_1", wr_a, 1);
        check("drain_idle_1b", idle_a, 0);
        sys_a.b_valid = 1'b1;
        cyc();
        sys_a.b_valid = 1'b0;
        check("drain_idle", idle_a, 1);
        check("drain_aw_still", acc_a.aw_ready, 0);
        quiesce = 1'b0; #1;
        check("resume_aw_ready", acc_a.aw_ready, 1);
        check("resume_idle", idle_a, 0);
        cyc();
        acc_a.aw_valid = 1'b0;
        check("resume_wr_cnt", wr_a, 1);
        sys_a.b_valid = 1'b1;
        cyc();
        sys_a.b_valid = 1'b0;
        check("wr_cnt_zero", wr_a, 0);

        // Underflow on a stray B, then clear
        sys_a.b_valid = 1'b1;
        cyc();
        sys_a.b_valid = 1'b0;
        check("unf_wr_cnt", wr_a, 0);
        check("unf_err", err_a, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("unf_clr", err_a, 0);

        // Error response on a non-last R beat
        sys_a.r_valid = 1'b1; sys_a.r_resp = 2'b11; sys_a.r_last = 1'b0;
        cyc();
        sys_a.r_valid = 1'b0; sys_a.r_resp = 2'b00;
        check("rerr_err", err_a, 1);
        check("rerr_rd_cnt", rd_a, 0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("rerr_clr", err_a, 0);
        acc_irq = 1'b1; #1;
        check("irq_acc", irq_a, 1);
        acc_irq = 1'b0;

        // Asynchronous reset with 3 reads / 2 writes outstanding on instance B
        aresetn = 1'b0; #1;
        aresetn = 1'b1;
        acc_a.ar_valid = 1'b1; acc_a.aw_valid = 1'b1;
        cyc(); cyc();
        acc_a.aw_valid = 1'b0;
        cyc();
        acc_a.ar_valid = 1'b0;
        check("pre_rst_rd_b", rd_b, 3);
        check("pre_rst_wr_b", wr_b, 2);
        check("pre_rst_rd_a", rd_a, 2);
        sys_a.r_valid = 1'b1; sys_a.r_resp = 2'b10;
        cyc();
        sys_a.r_valid = 1'b0; sys_a.r_resp = 2'b00;
        check("pre_rst_err_b", err_b, 1);
        acc_irq = 1'b1; #1;
        aresetn = 1'b0; #1;
        check("arst_rd_b", rd_b, 0);
        check("arst_wr_b", wr_b, 0);
        check("arst_err_b", err_b, 0);
        check("arst_irq_b", irq_b, 1);
        check("arst_rd_a", rd_a, 0);
        acc_irq = 1'b0; #1;
        check("arst_irq_b_0", irq_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
